// File: rtl/ssd1306_pkg.sv
// Shared types and constants for the SSD1306 frame streamer: FSM states, the
// init command list ROM and the address-window command bytes.
package ssd1306_pkg;

  typedef enum logic [2:0] {
    ST_POWER,
    ST_INIT,
    ST_IDLE,
    ST_CMD,
    ST_WIN,
    ST_FETCH,
    ST_SEND
  } state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_LOAD,
    TX_SHIFT
  } tx_state_t;

  localparam int INIT_LEN = 25;
  localparam int WIN_LEN  = 6;

  localparam logic [7:0] CMD_COL_ADDR  = 8'h21;
  localparam logic [7:0] CMD_PAGE_ADDR = 8'h22;

  // Display off, clocking, geometry, charge pump, horizontal addressing, display on.
  function automatic logic [7:0] init_byte(input int idx, input int pages);
    case (idx)
      0:       return 8'hAE;
      1:       return 8'hD5;
      2:       return 8'h80;
      3:       return 8'hA8;
      4:       return 8'(pages * 8 - 1);
      5:       return 8'hD3;
      6:       return 8'h00;
      7:       return 8'h40;
      8:       return 8'h8D;
      9:       return 8'h14;
      10:      return 8'h20;
      11:      return 8'h00;
      12:      return 8'hA1;
      13:      return 8'hC8;
      14:      return 8'hDA;
      15:      return (pages > 4) ? 8'h12 : 8'h02;
      16:      return 8'h81;
      17:      return 8'hCF;
      18:      return 8'hD9;
      19:      return 8'hF1;
      20:      return 8'hDB;
      21:      return 8'h40;
      22:      return 8'hA4;
      23:      return 8'hA6;
      24:      return 8'hAF;
      default: return 8'hE3;
    endcase
  endfunction

  function automatic logic [7:0] win_byte(input int idx, input int cols, input int pages);
    case (idx)
      0:       return CMD_COL_ADDR;
      1:       return 8'h00;
      2:       return 8'(cols - 1);
      3:       return CMD_PAGE_ADDR;
      4:       return 8'h00;
      default: return 8'(pages - 1);
    endcase
  endfunction

endpackage

// File: rtl/spi_byte_tx.sv
// Single-byte SPI mode-3 transmitter: cs-low load cycle, then 8 MSB-first bits.
// done fires in the last shift cycle so the next start lands in the cs-high gap.
module spi_byte_tx
  import ssd1306_pkg::*;
#(
  parameter int CLK_DIV = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] byte_in,
  input  logic       dc,
  output logic       done,
  output logic       io_sclk,
  output logic       io_sdin,
  output logic       io_cs,
  output logic       io_dc
);

  localparam int DIV_W = $clog2(CLK_DIV) + 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  tx_state_t        st;
  logic [DIV_W-1:0] div;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;

  assign done = (st == TX_SHIFT) && io_sclk && (div == DIV_LAST) && (bit_cnt == 3'd7);

  always_ff @(posedge clk) begin
    if (rst) begin
      st      <= TX_IDLE;
      div     <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      io_sclk <= 1'b1;
      io_sdin <= 1'b0;
      io_cs   <= 1'b1;
      io_dc   <= 1'b1;
    end else begin
      case (st)
        TX_IDLE: begin
          if (start) begin
            shreg <= byte_in;
            io_dc <= dc;
            io_cs <= 1'b0;
            st    <= TX_LOAD;
          end
        end
        TX_LOAD: begin
          io_sclk <= 1'b0;
          io_sdin <= shreg[7];
          shreg   <= {shreg[6:0], 1'b0};
          div     <= '0;
          bit_cnt <= '0;
          st      <= TX_SHIFT;
        end
        TX_SHIFT: begin
          if (div != DIV_LAST) begin
            div <= div + DIV_W'(1);
          end else begin
            div <= '0;
            if (!io_sclk) begin
              io_sclk <= 1'b1;
            end else if (bit_cnt == 3'd7) begin
              // sclk stays high; cs rises for the inter-byte gap
              io_cs <= 1'b1;
              st    <= TX_IDLE;
            end else begin
              io_sclk <= 1'b0;
              io_sdin <= shreg[7];
              shreg   <= {shreg[6:0], 1'b0};
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
        end
        default: st <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/ssd1306_frame_streamer.sv
// SSD1306 sequencer. States: POWER pin sequence | INIT init list | IDLE wait |
// CMD user byte | WIN address window | FETCH/SEND framebuffer bytes.
module ssd1306_frame_streamer
  import ssd1306_pkg::*;
#(
  parameter  int STARTUP_WAIT = 10_000_000,
  parameter  int CLK_DIV      = 1,
  parameter  int COLS         = 128,
  parameter  int PAGES        = 8,
  localparam int NBYTES       = COLS * PAGES,
  localparam int ADDR_W       = (NBYTES > 1) ? $clog2(NBYTES) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  output logic              frame_done,
  output logic              busy,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [7:0]        cmd_data,
  output logic              fb_rd_en,
  output logic [ADDR_W-1:0] fb_addr,
  input  logic [7:0]        fb_data,
  output logic              io_sclk,
  output logic              io_sdin,
  output logic              io_cs,
  output logic              io_dc,
  output logic              io_reset
);

  localparam int PWR_W = $clog2(3 * STARTUP_WAIT + 1);
  localparam logic [PWR_W-1:0]  PWR_LAST  = PWR_W'(3 * STARTUP_WAIT - 1);
  localparam logic [PWR_W-1:0]  RST_LO    = PWR_W'(STARTUP_WAIT);
  localparam logic [PWR_W-1:0]  RST_HI    = PWR_W'(2 * STARTUP_WAIT);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(NBYTES - 1);

  state_t           state;
  logic [PWR_W-1:0] pwr_cnt;
  logic [PWR_W-1:0] pwr_nxt;
  logic [4:0]       idx;
  logic             pending;
  logic             start;
  logic [7:0]       tx_byte;
  logic             tx_dc;
  logic             use_fb;
  logic             tx_done;
  logic [7:0]       tx_byte_in;

  assign pwr_nxt    = pwr_cnt + PWR_W'(1);
  // Data bytes are handed to the transmitter straight from the RAM read port.
  assign tx_byte_in = use_fb ? fb_data : tx_byte;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_POWER;
      pwr_cnt    <= '0;
      idx        <= '0;
      fb_addr    <= '0;
      pending    <= 1'b0;
      start      <= 1'b0;
      tx_byte    <= '0;
      tx_dc      <= 1'b0;
      use_fb     <= 1'b0;
      busy       <= 1'b1;
      cmd_ready  <= 1'b0;
      frame_done <= 1'b0;
      fb_rd_en   <= 1'b0;
      io_reset   <= 1'b1;
    end else begin
      start      <= 1'b0;
      frame_done <= 1'b0;
      fb_rd_en   <= 1'b0;
      case (state)
        ST_POWER: begin
          pwr_cnt  <= pwr_nxt;
          io_reset <= !((pwr_nxt >= RST_LO) && (pwr_nxt < RST_HI));
          if (pwr_cnt == PWR_LAST) begin
            state   <= ST_INIT;
            idx     <= '0;
            tx_byte <= init_byte(0, PAGES);
            tx_dc   <= 1'b0;
            start   <= 1'b1;
          end
        end
        ST_INIT: begin
          if (tx_done) begin
            if (int'(idx) == INIT_LEN - 1) begin
              state     <= ST_IDLE;
              busy      <= 1'b0;
              cmd_ready <= 1'b1;
            end else begin
              idx     <= idx + 5'd1;
              tx_byte <= init_byte(int'(idx) + 1, PAGES);
              start   <= 1'b1;
            end
          end
        end
        ST_IDLE: begin
          if (cmd_valid) begin
            state     <= ST_CMD;
            tx_byte   <= cmd_data;
            tx_dc     <= 1'b0;
            use_fb    <= 1'b0;
            start     <= 1'b1;
            busy      <= 1'b1;
            cmd_ready <= 1'b0;
          end else if (pending) begin
            state     <= ST_WIN;
            pending   <= 1'b0;
            idx       <= '0;
            fb_addr   <= '0;
            tx_byte   <= win_byte(0, COLS, PAGES);
            tx_dc     <= 1'b0;
            use_fb    <= 1'b0;
            start     <= 1'b1;
            busy      <= 1'b1;
            cmd_ready <= 1'b0;
          end
        end
        ST_CMD: begin
          if (tx_done) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
          end
        end
        ST_WIN: begin
          if (tx_done) begin
            if (int'(idx) == WIN_LEN - 1) begin
              state    <= ST_FETCH;
              fb_rd_en <= 1'b1;
              tx_dc    <= 1'b1;
            end else begin
              idx     <= idx + 5'd1;
              tx_byte <= win_byte(int'(idx) + 1, COLS, PAGES);
              start   <= 1'b1;
            end
          end
        end
        ST_FETCH: begin
          state  <= ST_SEND;
          use_fb <= 1'b1;
          start  <= 1'b1;
        end
        ST_SEND: begin
          if (tx_done) begin
            if (fb_addr == ADDR_LAST) begin
              state      <= ST_IDLE;
              frame_done <= 1'b1;
              fb_addr    <= '0;
              use_fb     <= 1'b0;
              busy       <= 1'b0;
              cmd_ready  <= 1'b1;
            end else begin
              state    <= ST_FETCH;
              fb_addr  <= fb_addr + ADDR_W'(1);
              fb_rd_en <= 1'b1;
            end
          end
        end
        default: state <= ST_POWER;
      endcase
      // Requests made during power-up or init are dropped; later ones merge.
      if (frame_start && (state != ST_POWER) && (state != ST_INIT)) pending <= 1'b1;
    end
  end

  spi_byte_tx #(.CLK_DIV(CLK_DIV)) u_tx (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .byte_in (tx_byte_in),
    .dc      (tx_dc),
    .done    (tx_done),
    .io_sclk (io_sclk),
    .io_sdin (io_sdin),
    .io_cs   (io_cs),
    .io_dc   (io_dc)
  );

endmodule

// File: tb/tb_ssd1306_frame_streamer.sv
// Directed bench: a CLK_DIV=2 4x2-panel instance driven through power-up, init,
// commands, frames and reset, plus a CLK_DIV=1 instance watched for SPI timing.
module tb_ssd1306_frame_streamer;

  logic clk = 1'b0;
  logic rst, frame_start, cmd_valid;
  logic [7:0] cmd_data;
  logic [7:0] fb_data = 8'h00;
  logic frame_done, busy, cmd_ready, fb_rd_en;
  logic [2:0] fb_addr;
  logic io_sclk, io_sdin, io_cs, io_dc, io_reset;

  logic frame_done1, busy1, cmd_ready1, fb_rd_en1;
  logic [2:0] fb_addr1;
  logic io_sclk1, io_sdin1, io_cs1, io_dc1, io_reset1;
  logic frame_start1 = 1'b0;
  logic cmd_valid1 = 1'b0;
  logic [7:0] cmd_data1 = 8'h00;
  logic [7:0] fb_data1 = 8'h00;

  always #5 clk = ~clk;

  ssd1306_frame_streamer #(.STARTUP_WAIT(4), .CLK_DIV(2), .COLS(4), .PAGES(2)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .frame_done(frame_done), .busy(busy),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .fb_rd_en(fb_rd_en), .fb_addr(fb_addr), .fb_data(fb_data),
    .io_sclk(io_sclk), .io_sdin(io_sdin), .io_cs(io_cs), .io_dc(io_dc), .io_reset(io_reset));

  ssd1306_frame_streamer #(.STARTUP_WAIT(4), .CLK_DIV(1), .COLS(4), .PAGES(2)) dut1 (
    .clk(clk), .rst(rst), .frame_start(frame_start1), .frame_done(frame_done1), .busy(busy1),
    .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1), .cmd_data(cmd_data1),
    .fb_rd_en(fb_rd_en1), .fb_addr(fb_addr1), .fb_data(fb_data1),
    .io_sclk(io_sclk1), .io_sdin(io_sdin1), .io_cs(io_cs1), .io_dc(io_dc1), .io_reset(io_reset1));

  // Framebuffer RAM model: content is ~address, one-cycle read latency.
  always @(posedge clk) if (fb_rd_en) fb_data <= ~{5'b0, fb_addr};

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vec = 0;
  int miscmp = 0;

  // Panel-side decoders and timing watchers.
  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic [7:0] sh0, sh1;
  int bits0 = 0, bits1 = 0, run1 = 0;
  logic sclk_p0 = 1'b1, sdin_p0 = 1'b0, busy_p0 = 1'b1;
  logic sclk_p1 = 1'b1, sdin_p1 = 1'b0;
  int m3_viol = 0, h1_viol = 0;
  int fd_count = 0, fd_cyc = 0, busy_rise = 0, b1_fall = -1;

  always @(negedge clk) begin
    if (io_cs) bits0 = 0;
    else if (!sclk_p0 && io_sclk) begin
      if (io_sdin !== sdin_p0) m3_viol++;
      sh0 = {sh0[6:0], io_sdin};
      bits0++;
      if (bits0 == 8) begin q0.push_back({io_dc, sh0}); bits0 = 0; end
    end
    if (frame_done) begin fd_count++; fd_cyc = cyc; end
    if (busy && !busy_p0) busy_rise = cyc;
    sclk_p0 = io_sclk; sdin_p0 = io_sdin; busy_p0 = busy;

    if (io_cs1) begin bits1 = 0; run1 = 0; end
    else begin
      if (io_sclk1 != sclk_p1) begin
        if (run1 != 1) h1_viol++;
        run1 = 1;
      end else run1++;
      if (!sclk_p1 && io_sclk1) begin
        if (io_sdin1 !== sdin_p1) m3_viol++;
        sh1 = {sh1[6:0], io_sdin1};
        bits1++;
        if (bits1 == 8) begin q1.push_back({io_dc1, sh1}); bits1 = 0; end
      end
    end
    if (!busy1 && b1_fall < 0) b1_fall = cyc;
    sclk_p1 = io_sclk1; sdin_p1 = io_sdin1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp)
    else begin
      miscmp++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [8:0] exp_frame[14] = '{9'h021, 9'h000, 9'h003, 9'h022, 9'h000, 9'h001,
                                9'h1FF, 9'h1FE, 9'h1FD, 9'h1FC, 9'h1FB, 9'h1FA, 9'h1F9, 9'h1F8};

  initial begin
    int c0, c0_first, first_cs, n, base, fdb, guard, dc_or;
    logic [15:0] tr;

    rst = 1'b1; frame_start = 1'b0; cmd_valid = 1'b0; cmd_data = 8'h00;
    tick(3);
    check("reset_pins", {io_sclk, io_sdin, io_cs, io_dc, io_reset, busy, cmd_ready, frame_done, fb_rd_en},
          9'b1_0_1_1_1_1_0_0_0);
    check("reset_fb_addr", fb_addr, 0);

    // Power-up sequence; a frame request during POWER and INIT must be dropped.
    rst = 1'b0; c0 = cyc; c0_first = cyc; first_cs = -1;
    for (int k = 0; k < 16; k++) begin
      tr[k] = io_reset;
      if (!io_cs && first_cs < 0) first_cs = k;
      frame_start = (k == 2) || (k == 14);
      tick(1);
    end
    frame_start = 1'b0;
    check("power_io_reset_trace", tr, 16'hFF0F);
    check("first_cs_fall_cycle", first_cs, 13);

    guard = 0;
    while (busy && guard < 3000) begin guard++; tick(1); end
    check("init_done_cycle", cyc - c0, 862);
    check("init_byte_count", q0.size(), 25);
    check("init_first_byte", q0[0], 9'h0AE);
    check("init_mux_ratio", q0[4], 9'h00F);
    check("init_last_byte", q0[24], 9'h0AF);
    dc_or = 0;
    foreach (q0[i]) dc_or |= q0[i][8];
    check("init_dc_all_zero", dc_or, 0);
    tick(10);
    check("idle_after_drop", {busy, cmd_ready, frame_done}, 3'b010);
    check("no_frame_after_drop", q0.size(), 25);

    // Single user command 0xA7.
    cmd_valid = 1'b1; cmd_data = 8'hA7;
    tick(1);
    cmd_valid = 1'b0;
    check("cmd_handshake_flags", {cmd_ready, busy}, 2'b01);
    n = 0;
    while (busy && n < 200) begin n++; tick(1); end
    check("cmd_busy_cycles", n, 34);
    check("cmd_byte", q0[25], 9'h0A7);
    check("cmd_ready_back", cmd_ready, 1'b1);

    // One full frame.
    base = q0.size(); fdb = fd_count;
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
    guard = 0;
    while (fd_count == fdb && guard < 2000) begin guard++; tick(1); end
    tick(20);
    check("frame_done_count", fd_count - fdb, 1);
    check("frame_length", fd_cyc - busy_rise, 484);
    check("frame_byte_count", q0.size() - base, 14);
    for (int i = 0; i < 14; i++) check($sformatf("frame_byte_%0d", i), q0[base + i], exp_frame[i]);
    check("frame_idle_after", {busy, fb_addr}, 4'b0000);

    // Command and frame requested together, then two merged requests mid-frame.
    base = q0.size(); fdb = fd_count;
    cmd_valid = 1'b1; cmd_data = 8'h81; frame_start = 1'b1;
    tick(1);
    cmd_valid = 1'b0; frame_start = 1'b0;
    tick(150);
    frame_start = 1'b1; tick(1); frame_start = 1'b0;
    tick(20);
    frame_start = 1'b1; tick(1); frame_start = 1'b0;
    guard = 0;
    while (fd_count < fdb + 2 && guard < 3000) begin guard++; tick(1); end
    tick(200);
    check("merge_frame_count", fd_count - fdb, 2);
    check("merge_byte_count", q0.size() - base, 29);
    check("merge_cmd_first", q0[base], 9'h081);
    check("merge_frame1_start", q0[base + 1], 9'h021);
    check("merge_frame2_start", q0[base + 15], 9'h021);
    check("merge_frame2_last", q0[base + 28], 9'h1F8);

    // Reset in the middle of a data byte.
    frame_start = 1'b1; tick(1); frame_start = 1'b0;
    guard = 0;
    while (!(io_dc && !io_cs) && guard < 1000) begin guard++; tick(1); end
    check("reached_data_byte", {io_dc, io_cs}, 2'b10);
    tick(5);
    fdb = fd_count;
    rst = 1'b1;
    tick(1);
    check("rst_pins", {io_cs, io_sclk, busy, cmd_ready, io_reset, fb_rd_en, frame_done}, 7'b1110100);
    rst = 1'b0; c0 = cyc; base = q0.size();
    for (int k = 0; k < 16; k++) begin tr[k] = io_reset; tick(1); end
    check("rerun_io_reset_trace", tr, 16'hFF0F);
    guard = 0;
    while (busy && guard < 3000) begin guard++; tick(1); end
    check("rerun_init_done_cycle", cyc - c0, 862);
    check("rerun_first_byte", q0[base], 9'h0AE);
    check("rerun_byte_count", q0.size() - base, 25);
    tick(100);
    check("rerun_no_frame", {busy, fd_count - fdb}, 33'd0);

    // CLK_DIV=1 instance and SPI mode-3 timing over the whole run.
    check("div1_init_done_cycle", b1_fall - c0_first, 462);
    check("div1_byte_count", q1.size(), 50);
    check("div1_first_byte", q1[0], 9'h0AE);
    check("div1_mux_ratio", q1[4], 9'h00F);
    check("div1_half_period", h1_viol, 0);
    check("mode3_sdin_stable", m3_viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
    $finish;
  end

endmodule
